// File: rtl/wbm_pkg.sv
// Shared constants for the Wishbone command master: state encodings,
// timeout read-back value and the per-beat address increment.
package wbm_pkg;

  typedef enum logic [1:0] {
    WBM_IDLE  = 2'd0,
    WBM_FETCH = 2'd1,
    WBM_BUS   = 2'd2,
    WBM_RESP  = 2'd3
  } wbm_state_e;

  // Plain vector encodings so legacy code can compare against raw state bits
  localparam logic [1:0] ST_IDLE  = WBM_IDLE;
  localparam logic [1:0] ST_FETCH = WBM_FETCH;
  localparam logic [1:0] ST_BUS   = WBM_BUS;
  localparam logic [1:0] ST_RESP  = WBM_RESP;

  localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;
  localparam int unsigned WORD_INCR          = 4;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Fabric-side Wishbone bus bundle driven by wb_cmd_master (master modport)
// and answered by the register responders (slave modport).
interface wb_cmd_master_if #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32
);
  logic [ADDRWIDTH-1:0] WBm_ADR_o;
  logic                 WBm_CYC_o;
  logic                 WBm_STB_o;
  logic                 WBm_WE_o;
  logic                 WBm_RD_o;
  logic [3:0]           WBm_BYTE_STB_o;
  logic [DATAWIDTH-1:0] WBm_WR_DAT_o;
  logic [DATAWIDTH-1:0] WBm_RD_DAT_i;
  logic                 WBm_ACK_i;

  modport master (
    output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
    output WBm_BYTE_STB_o, WBm_WR_DAT_o,
    input  WBm_RD_DAT_i, WBm_ACK_i
  );

  modport slave (
    input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
    input  WBm_BYTE_STB_o, WBm_WR_DAT_o,
    output WBm_RD_DAT_i, WBm_ACK_i
  );
endinterface

// File: rtl/wbm_timeout_cntr.sv
// ACK watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT_CYCLES-th cycle without ACK is reached.
module wbm_timeout_cntr #(
  parameter int TIMEOUT_WIDTH  = 3,
  parameter int TIMEOUT_CYCLES = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The current cycle is counted too, so the limit is one below the cycle count
  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] cnt_q;

  assign expired = enable && (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone initiator: turns valid/ready read/write commands into single or
// incrementing-burst bus cycles. Define WBM_TIMEOUT_EN to enable the ACK timeout.
module wb_cmd_master #(
  parameter int                         ADDRWIDTH          = 17,
  parameter int                         DATAWIDTH          = 32,
  parameter int                         LEN_WIDTH          = 4,
  parameter int                         TIMEOUT_WIDTH      = 3,
  parameter int                         TIMEOUT_CYCLES     = 7,
  parameter logic [DATAWIDTH-1:0]       DEFAULT_READ_VALUE = wbm_pkg::DEFAULT_READ_VALUE
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  input  logic [3:0]           cmd_byte_stb_i,
  input  logic                 wdat_valid_i,
  output logic                 wdat_ready_o,
  input  logic [DATAWIDTH-1:0] wdat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 rsp_last_o,
  wb_cmd_master_if.master      wbm,
  output logic                 busy_o
);
  import wbm_pkg::*;

  logic [1:0]           state_q;
  logic                 we_q;
  logic [ADDRWIDTH-1:0] adr_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_q;
  logic [3:0]           byte_stb_q;
  logic [DATAWIDTH-1:0] wdat_q;
  logic [DATAWIDTH-1:0] rsp_dat_q;
  logic                 err_q;
  logic                 in_bus;
  logic                 in_resp;
  logic                 last_beat;
  logic                 timeout_hit;
  logic                 unused_adr_lsb;

  assign unused_adr_lsb = ^cmd_adr_i[1:0];

`ifdef WBM_TIMEOUT_EN
  wbm_timeout_cntr #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (WB_CLK),
    .rst    (WB_RST),
    .clear  (!in_bus),
    .enable (in_bus && !wbm.WBm_ACK_i),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_WIDTH[0] ^ TIMEOUT_CYCLES[0];
  assign timeout_hit        = 1'b0;
`endif

  assign in_bus    = (state_q == ST_BUS);
  assign in_resp   = (state_q == ST_RESP);
  assign last_beat = (beat_q == len_q) || err_q;

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign wdat_ready_o = (state_q == ST_FETCH);
  assign busy_o       = (state_q != ST_IDLE);

  // Response fields are only meaningful in RESP; elsewhere they read as zero
  assign rsp_valid_o = in_resp;
  assign rsp_dat_o   = in_resp ? rsp_dat_q : '0;
  assign rsp_err_o   = in_resp && err_q;
  assign rsp_last_o  = in_resp && last_beat;

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    wbm.WBm_CYC_o      = 1'b0;
    wbm.WBm_STB_o      = 1'b0;
    wbm.WBm_WE_o       = 1'b0;
    wbm.WBm_RD_o       = 1'b0;
    wbm.WBm_ADR_o      = '0;
    wbm.WBm_BYTE_STB_o = '0;
    wbm.WBm_WR_DAT_o   = '0;
    if (in_bus) begin
      wbm.WBm_CYC_o      = 1'b1;
      wbm.WBm_STB_o      = 1'b1;
      wbm.WBm_WE_o       = we_q;
      wbm.WBm_RD_o       = !we_q;
      wbm.WBm_ADR_o      = adr_q;
      wbm.WBm_BYTE_STB_o = byte_stb_q;
      wbm.WBm_WR_DAT_o   = wdat_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      byte_stb_q <= '0;
      wdat_q     <= '0;
      rsp_dat_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            we_q       <= cmd_we_i;
            adr_q      <= {cmd_adr_i[ADDRWIDTH-1:2], 2'b00};
            len_q      <= cmd_len_i;
            byte_stb_q <= cmd_byte_stb_i;
            beat_q     <= '0;
            err_q      <= 1'b0;
            state_q    <= cmd_we_i ? ST_FETCH : ST_BUS;
          end
        end
        ST_FETCH: begin
          if (wdat_valid_i) begin
            wdat_q  <= wdat_i;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          // An ACK in the expiry cycle still completes the beat normally
          if (wbm.WBm_ACK_i) begin
            rsp_dat_q <= we_q ? '0 : wbm.WBm_RD_DAT_i;
            err_q     <= 1'b0;
            state_q   <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_dat_q <= DEFAULT_READ_VALUE;
            err_q     <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            if (last_beat) begin
              state_q <= ST_IDLE;
            end else begin
              beat_q  <= beat_q + 1'b1;
              adr_q   <= adr_q + ADDRWIDTH'(WORD_INCR);
              state_q <= we_q ? ST_FETCH : ST_BUS;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master; the timeout scenario follows WBM_TIMEOUT_EN
// (abort with error when defined, indefinite wait for a late ACK otherwise).
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [16:0] cmd_adr = '0;
  logic [3:0]  cmd_len = '0;
  logic [3:0]  cmd_bstb = '0;
  logic        wdat_valid = 1'b0;
  logic [31:0] wdat = '0;
  logic        rsp_ready = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rd_word = '0;

  logic        cmd_ready, wdat_ready, rsp_valid, rsp_err, rsp_last, busy;
  logic [31:0] rsp_dat;

  wb_cmd_master_if #(.ADDRWIDTH(17), .DATAWIDTH(32)) bus ();

  assign bus.WBm_ACK_i    = ack;
  assign bus.WBm_RD_DAT_i = rd_word ^ {15'b0, bus.WBm_ADR_o};

  wb_cmd_master dut (
    .WB_CLK        (clk),
    .WB_RST        (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_we_i      (cmd_we),
    .cmd_adr_i     (cmd_adr),
    .cmd_len_i     (cmd_len),
    .cmd_byte_stb_i(cmd_bstb),
    .wdat_valid_i  (wdat_valid),
    .wdat_ready_o  (wdat_ready),
    .wdat_i        (wdat),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_dat_o     (rsp_dat),
    .rsp_err_o     (rsp_err),
    .rsp_last_o    (rsp_last),
    .wbm           (bus),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wishbone slave model: ACK in the ack_at-th STB cycle of a beat (0 = never)
  int          ack_at = 1;
  bit          spurious = 1'b0;
  int          stb_cnt = 0, stb_starts = 0, stb_total = 0, stb_cyc = 0, b2b = 0;
  bit          prev_ack = 1'b0, prev_stb = 1'b0;
  logic [16:0] b_adr[$];
  logic [31:0] b_dat[$];
  logic [1:0]  b_wr[$];
  logic [3:0]  b_bstb[$];

  always @(negedge clk) begin
    if (bus.WBm_STB_o === 1'b1) begin
      if (!prev_stb) begin
        stb_starts++;
        stb_cyc = cyc;
      end
      if (prev_ack) b2b++;
      stb_cnt++;
      stb_total++;
      ack = (ack_at != 0) && (stb_cnt == ack_at);
      if (ack) begin
        b_adr.push_back(bus.WBm_ADR_o);
        b_dat.push_back(bus.WBm_WR_DAT_o);
        b_wr.push_back({bus.WBm_WE_o, bus.WBm_RD_o});
        b_bstb.push_back(bus.WBm_BYTE_STB_o);
      end
    end else begin
      stb_cnt = 0;
      ack     = spurious;
    end
    prev_ack = ack && (bus.WBm_STB_o === 1'b1);
    prev_stb = (bus.WBm_STB_o === 1'b1);
  end

  // Write-data source with an optional stall before one beat
  logic [31:0] wq[$];
  int          sent = 0, stall_beat = -1, stall_left = 0;

  always @(posedge clk) begin
    if (wdat_valid && wdat_ready === 1'b1) begin
      void'(wq.pop_front());
      sent++;
    end
  end

  always @(negedge clk) begin
    if (wdat_ready === 1'b1 && wq.size() > 0) begin
      if (sent == stall_beat && stall_left > 0) begin
        stall_left--;
        wdat_valid = 1'b0;
      end else begin
        wdat_valid = 1'b1;
        wdat       = wq[0];
      end
    end else begin
      wdat_valid = 1'b0;
    end
  end

  // Response sink: holds ready low hold_cfg cycles and watches field stability
  logic [31:0] r_dat[$];
  logic        r_err[$];
  logic        r_last[$];
  int          r_cyc[$];
  int          hold_cfg = 0, hold = 0, stab_bad = 0, first_cyc = 0;
  bit          in_rsp = 1'b0;
  logic [31:0] s_dat;
  logic        s_err, s_last;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (!in_rsp) begin
        in_rsp    = 1'b1;
        hold      = hold_cfg;
        first_cyc = cyc;
        s_dat     = rsp_dat;
        s_err     = rsp_err;
        s_last    = rsp_last;
      end else if (rsp_dat !== s_dat || rsp_err !== s_err || rsp_last !== s_last) begin
        stab_bad++;
      end
      rsp_ready = (hold == 0);
      if (hold > 0) hold--;
      if (rsp_ready) begin
        r_dat.push_back(rsp_dat);
        r_err.push_back(rsp_err);
        r_last.push_back(rsp_last);
        r_cyc.push_back(first_cyc);
        in_rsp = 1'b0;
      end
    end else begin
      rsp_ready = 1'b0;
      in_rsp    = 1'b0;
    end
  end

  task automatic clear_logs();
    @(posedge clk);
    #1;
    b_adr.delete(); b_dat.delete(); b_wr.delete(); b_bstb.delete();
    r_dat.delete(); r_err.delete(); r_last.delete(); r_cyc.delete();
    stb_starts = 0;
    stb_total  = 0;
  endtask

  task automatic send_cmd(input logic we, input logic [16:0] adr,
                          input logic [3:0] len, input logic [3:0] bstb);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bstb = bstb;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && r_dat.size() < n; i++) @(negedge clk);
    check(tag, r_dat.size(), n);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_ctl", {busy, wdat_ready, rsp_valid, rsp_err, rsp_last,
                      bus.WBm_CYC_o, bus.WBm_STB_o, bus.WBm_WE_o, bus.WBm_RD_o}, 9'h0);
    check("rst_dat", rsp_dat | bus.WBm_WR_DAT_o | {15'b0, bus.WBm_ADR_o}, 32'h0);
    rst = 1'b0;

    // Single read, ACK first BUS cycle, response held 3 cycles
    clear_logs();
    ack_at = 1; rd_word = 32'h1234_5678; hold_cfg = 3;
    send_cmd(1'b0, 17'h00000, 4'd0, 4'hF);
    wait_rsp("rd1_cnt", 1, 30);
    check("rd1_stb_lat", stb_cyc - acc_cyc, 1);
    check("rd1_rsp_lat", r_cyc[0] - acc_cyc, 2);
    check("rd1_dat", r_dat[0], 32'h1234_5678);
    check("rd1_err_last", {r_err[0], r_last[0]}, 2'b01);
    check("rd1_we_rd", b_wr[0], 2'b01);
    check("rd1_stable", stab_bad, 0);
    hold_cfg = 0;

    // 4-beat write, 2-cycle data stall before beat 2, busy blocks new commands
    clear_logs();
    wq = '{32'd1, 32'd2, 32'd3, 32'd4};
    sent = 0; stall_beat = 1; stall_left = 2; ack_at = 1;
    send_cmd(1'b1, 17'h00100, 4'd3, 4'b0110);
    cmd_valid = 1'b1;
    check("wr_busy", {busy, cmd_ready}, 2'b10);
    @(negedge clk);
    check("wr_busy_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    wait_rsp("wr_cnt", 4, 60);
    check("wr_adr0", b_adr[0], 17'h00100);
    check("wr_adr1", b_adr[1], 17'h00104);
    check("wr_adr2", b_adr[2], 17'h00108);
    check("wr_adr3", b_adr[3], 17'h0010C);
    check("wr_dat", {b_dat[0][7:0], b_dat[1][7:0], b_dat[2][7:0], b_dat[3][7:0]}, 32'h01020304);
    check("wr_bstb", {b_bstb[0], b_bstb[3]}, 8'h66);
    check("wr_we_rd", {b_wr[0], b_wr[3]}, 4'b1010);
    check("wr_last", {r_last[3], r_last[2], r_last[1], r_last[0]}, 4'b1000);
    check("wr_err", {r_err[3], r_err[2], r_err[1], r_err[0]}, 4'b0000);
    check("wr_rdat", r_dat[0] | r_dat[3], 32'h0);
    check("wr_last_lat", r_cyc[3] - acc_cyc, 14);
    check("wr_stb_starts", stb_starts, 4);

`ifdef WBM_TIMEOUT_EN
    // 3-beat read, slave never ACKs: one aborted beat with error
    clear_logs();
    ack_at = 0; rd_word = 32'h0;
    send_cmd(1'b0, 17'h00040, 4'd2, 4'hF);
    wait_rsp("to_cnt", 1, 40);
    repeat (10) @(negedge clk);
    check("to_cnt_after", r_dat.size(), 1);
    check("to_dat", r_dat[0], 32'hBAD_FAB_AC);
    check("to_err_last", {r_err[0], r_last[0]}, 2'b11);
    check("to_stb_cycles", stb_total, 7);
    check("to_stb_starts", stb_starts, 1);
    check("to_rsp_lat", r_cyc[0] - acc_cyc, 8);
`else
    // Without the watchdog a late ACK still completes the beat cleanly
    clear_logs();
    ack_at = 20; rd_word = 32'h5555_0000;
    send_cmd(1'b0, 17'h00040, 4'd0, 4'hF);
    wait_rsp("late_cnt", 1, 60);
    check("late_dat", r_dat[0], 32'h5555_0040);
    check("late_err_last", {r_err[0], r_last[0]}, 2'b01);
    check("late_stb_cycles", stb_total, 20);
    check("late_rsp_lat", r_cyc[0] - acc_cyc, 21);
`endif

    // ACK in the 7th BUS cycle wins over the timeout
    clear_logs();
    ack_at = 7; rd_word = 32'h0F0F_0F0F;
    send_cmd(1'b0, 17'h00080, 4'd0, 4'hF);
    wait_rsp("ack7_cnt", 1, 40);
    check("ack7_dat", r_dat[0], 32'h0F0F_0F8F);
    check("ack7_err_last", {r_err[0], r_last[0]}, 2'b01);
    check("ack7_rsp_lat", r_cyc[0] - acc_cyc, 8);

    // 2-beat read across the top of the aperture
    clear_logs();
    ack_at = 1; rd_word = 32'hCAFE_0000;
    send_cmd(1'b0, 17'h1FFFC, 4'd1, 4'hF);
    wait_rsp("wrap_cnt", 2, 30);
    check("wrap_adr0", b_adr[0], 17'h1FFFC);
    check("wrap_adr1", b_adr[1], 17'h00000);
    check("wrap_dat0", r_dat[0], 32'hCAFF_FFFC);
    check("wrap_dat1", r_dat[1], 32'hCAFE_0000);
    check("wrap_last", {r_last[1], r_last[0]}, 2'b10);
    check("wrap_lat", r_cyc[1] - acc_cyc, 4);

    // Stray ACK while idle is ignored
    clear_logs();
    spurious = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_idle", {busy, rsp_valid, cmd_ready}, 3'b001);
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_rsp", r_dat.size(), 0);

    // Reset while STB is high abandons the cycle silently
    clear_logs();
    ack_at = 0;
    send_cmd(1'b0, 17'h00200, 4'd3, 4'hF);
    check("mid_stb", bus.WBm_STB_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst", {bus.WBm_CYC_o, bus.WBm_STB_o, busy, cmd_ready, rsp_valid}, 5'b00010);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_no_rsp", r_dat.size(), 0);
    check("mid_stb_starts", stb_starts, 1);

    check("no_b2b_stb", b2b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
